// File: rtl/avalon_pkg.sv
// avalon_pkg: shared arbitration state encoding for Avalon initiators
package avalon_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
endpackage

// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter: round-robin arbiter muxing two Avalon-MM requesters onto one downstream port
module avalon_master_arbiter
  import avalon_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          r0_read,
  input  logic          r0_write,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_address,
  input  logic [DW-1:0] r0_writedata,
  output logic [DW-1:0] r0_readdata,
  output logic          r0_waitrequest,
  input  logic          r1_read,
  input  logic          r1_write,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_address,
  input  logic [DW-1:0] r1_writedata,
  output logic [DW-1:0] r1_readdata,
  output logic          r1_waitrequest,
  output logic          avm_read,
  output logic          avm_write,
  output logic [AW-1:0] avm_address,
  output logic [DW-1:0] avm_writedata,
  input  logic [DW-1:0] avm_readdata,
  input  logic          avm_waitrequest,
  output logic [1:0]    grant,
  output logic [15:0]   cnt0,
  output logic [15:0]   cnt1
);
  arb_state_t state, nxt;
  logic last;
  logic req0, req1, own0, own1, done0, done1;

  assign req0  = r0_read | r0_write;
  assign req1  = r1_read | r1_write;
  assign own0  = state == OWN0;
  assign own1  = state == OWN1;
  assign done0 = own0 & req0 & ~avm_waitrequest;
  assign done1 = own1 & req1 & ~avm_waitrequest;

  // Next owner: ties go to whoever was not granted last; a locked completion keeps ownership
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (req0 && req1) ? (last ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
      OWN0:    nxt = !req0 ? IDLE : (!done0 || r0_lock) ? OWN0 : req1 ? OWN1 : IDLE;
      OWN1:    nxt = !req1 ? IDLE : (!done1 || r1_lock) ? OWN1 : req0 ? OWN0 : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Owner register, last-granted tracking and per-requester completion counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt0  <= '0;
      cnt1  <= '0;
    end else begin
      state <= nxt;
      if (nxt != IDLE) last <= (nxt == OWN1);
      if (done0) cnt0 <= cnt0 + 16'd1;
      if (done1) cnt1 <= cnt1 + 16'd1;
    end
  end

  assign grant          = {own1, own0};
  assign avm_read       = own0 ? r0_read : own1 ? r1_read : 1'b0;
  assign avm_write      = own0 ? r0_write : own1 ? r1_write : 1'b0;
  assign avm_address    = own0 ? r0_address : own1 ? r1_address : '0;
  assign avm_writedata  = own0 ? r0_writedata : own1 ? r1_writedata : '0;
  assign r0_waitrequest = own0 ? avm_waitrequest : 1'b1;
  assign r1_waitrequest = own1 ? avm_waitrequest : 1'b1;
  assign r0_readdata    = own0 ? avm_readdata : '0;
  assign r1_readdata    = own1 ? avm_readdata : '0;
endmodule

// File: tb/tb_avalon_master_arbiter.sv
// tb_avalon_master_arbiter: directed scenario checks for the two-requester arbiter
module tb_avalon_master_arbiter;
  logic        clk = 0, reset_n = 0;
  logic        r0_read = 0, r0_write = 0, r0_lock = 0;
  logic [31:0] r0_address = 0, r0_writedata = 0, r0_readdata;
  logic        r0_waitrequest;
  logic        r1_read = 0, r1_write = 0, r1_lock = 0;
  logic [31:0] r1_address = 0, r1_writedata = 0, r1_readdata;
  logic        r1_waitrequest;
  logic        avm_read, avm_write;
  logic [31:0] avm_address, avm_writedata;
  logic [31:0] avm_readdata = 32'hCAFE_0001;
  logic        avm_waitrequest = 0;
  logic [1:0]  grant;
  logic [15:0] cnt0, cnt1;
  int errors = 0, checks = 0;

  avalon_master_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_lock(r0_lock), .r0_address(r0_address),
    .r0_writedata(r0_writedata), .r0_readdata(r0_readdata), .r0_waitrequest(r0_waitrequest),
    .r1_read(r1_read), .r1_write(r1_write), .r1_lock(r1_lock), .r1_address(r1_address),
    .r1_writedata(r1_writedata), .r1_readdata(r1_readdata), .r1_waitrequest(r1_waitrequest),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r0_read = 0; r0_write = 0; r0_lock = 0;
    r1_read = 0; r1_write = 0; r1_lock = 0;
    avm_waitrequest = 0;
    reset_n = 0;
    step();
    reset_n = 1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || avm_read !== 1'b0 || avm_write !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0)
      begin errors++; $display("FAIL reset_outputs: grant=%b rd=%b wr=%b cnt0=%0d cnt1=%0d want 00 0 0 0 0", grant, avm_read, avm_write, cnt0, cnt1); end
    checks++;
    if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1)
      begin errors++; $display("FAIL reset_wait: w0=%b w1=%b want 1 1", r0_waitrequest, r1_waitrequest); end
    do_reset();
  endtask

  task automatic test_single_read();
    r0_read = 1; r0_address = 32'h100;
    #1;
    checks++;
    if (grant !== 2'b00 || r0_waitrequest !== 1'b1)
      begin errors++; $display("FAIL single_latency: grant=%b w0=%b want 00 1", grant, r0_waitrequest); end
    step();
    checks++;
    if (grant !== 2'b01 || avm_address !== 32'h100 || avm_read !== 1'b1 || r0_waitrequest !== 1'b0 || r0_readdata !== 32'hCAFE_0001)
      begin errors++; $display("FAIL single_own: grant=%b addr=%h rd=%b w0=%b rdata=%h want 01 100 1 0 cafe0001", grant, avm_address, avm_read, r0_waitrequest, r0_readdata); end
    step();
    r0_read = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || cnt0 !== 16'd1 || avm_read !== 1'b0)
      begin errors++; $display("FAIL single_done: grant=%b cnt0=%0d rd=%b want 00 1 0", grant, cnt0, avm_read); end
  endtask

  task automatic test_tie();
    do_reset();
    r0_read = 1; r0_address = 32'hA0;
    r1_read = 1; r1_address = 32'hA1;
    step();
    checks++;
    if (grant !== 2'b01 || avm_address !== 32'hA0 || r1_waitrequest !== 1'b1)
      begin errors++; $display("FAIL tie_first: grant=%b addr=%h w1=%b want 01 a0 1", grant, avm_address, r1_waitrequest); end
    step();
    r0_read = 0;
    #1;
    checks++;
    if (grant !== 2'b10 || avm_address !== 32'hA1 || cnt0 !== 16'd1 || r1_waitrequest !== 1'b0)
      begin errors++; $display("FAIL tie_second: grant=%b addr=%h cnt0=%0d w1=%b want 10 a1 1 0", grant, avm_address, cnt0, r1_waitrequest); end
    step();
    r1_read = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || cnt1 !== 16'd1)
      begin errors++; $display("FAIL tie_idle: grant=%b cnt1=%0d want 00 1", grant, cnt1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    r1_write = 1; r1_lock = 1; r1_address = 32'h200; r1_writedata = 32'h1111_0000;
    step();
    r0_read = 1; r0_address = 32'h300;
    #1;
    checks++;
    if (grant !== 2'b10 || avm_write !== 1'b1 || avm_writedata !== 32'h1111_0000 || r0_waitrequest !== 1'b1)
      begin errors++; $display("FAIL b2b_first: grant=%b wr=%b wdata=%h w0=%b want 10 1 11110000 1", grant, avm_write, avm_writedata, r0_waitrequest); end
    step();
    r1_lock = 0; r1_address = 32'h204; r1_writedata = 32'h2222_0000;
    #1;
    checks++;
    if (grant !== 2'b10 || cnt1 !== 16'd1 || avm_writedata !== 32'h2222_0000 || avm_address !== 32'h204)
      begin errors++; $display("FAIL b2b_locked: grant=%b cnt1=%0d wdata=%h addr=%h want 10 1 22220000 204", grant, cnt1, avm_writedata, avm_address); end
    step();
    r1_write = 0;
    #1;
    checks++;
    if (grant !== 2'b01 || cnt1 !== 16'd2 || avm_address !== 32'h300 || avm_write !== 1'b0)
      begin errors++; $display("FAIL b2b_handover: grant=%b cnt1=%0d addr=%h wr=%b want 01 2 300 0", grant, cnt1, avm_address, avm_write); end
    step();
    r0_read = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || cnt0 !== 16'd1)
      begin errors++; $display("FAIL b2b_idle: grant=%b cnt0=%0d want 00 1", grant, cnt0); end
  endtask

  task automatic test_wait();
    avm_waitrequest = 1;
    r0_read = 1; r0_address = 32'h400;
    step();
    r1_read = 1; r1_address = 32'h500;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (grant !== 2'b01 || r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1 || cnt0 !== 16'd1)
        begin errors++; $display("FAIL wait_stall[%0d]: grant=%b w0=%b w1=%b cnt0=%0d want 01 1 1 1", i, grant, r0_waitrequest, r1_waitrequest, cnt0); end
      step();
    end
    avm_waitrequest = 0;
    #1;
    checks++;
    if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1)
      begin errors++; $display("FAIL wait_release: w0=%b w1=%b want 0 1", r0_waitrequest, r1_waitrequest); end
    step();
    r0_read = 0;
    #1;
    checks++;
    if (grant !== 2'b10 || cnt0 !== 16'd2)
      begin errors++; $display("FAIL wait_handover: grant=%b cnt0=%0d want 10 2", grant, cnt0); end
    step();
    r1_read = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || cnt1 !== 16'd3)
      begin errors++; $display("FAIL wait_idle: grant=%b cnt1=%0d want 00 3", grant, cnt1); end
  endtask

  task automatic test_drop();
    avm_waitrequest = 1;
    r0_read = 1; r0_lock = 1;
    step();
    checks++;
    if (grant !== 2'b01)
      begin errors++; $display("FAIL drop_own: grant=%b want 01", grant); end
    r0_read = 0;
    step();
    checks++;
    if (grant !== 2'b00 || cnt0 !== 16'd2)
      begin errors++; $display("FAIL drop_idle: grant=%b cnt0=%0d want 00 2", grant, cnt0); end
    r0_lock = 0;
    avm_waitrequest = 0;
  endtask

  task automatic test_reset_mid();
    avm_waitrequest = 1;
    r1_write = 1; r1_address = 32'h600;
    step();
    checks++;
    if (grant !== 2'b10 || avm_write !== 1'b1)
      begin errors++; $display("FAIL midrst_pre: grant=%b wr=%b want 10 1", grant, avm_write); end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (avm_write !== 1'b0 || grant !== 2'b00 || cnt1 !== 16'd0 || cnt0 !== 16'd0 || r1_waitrequest !== 1'b1)
      begin errors++; $display("FAIL midrst_abort: wr=%b grant=%b cnt1=%0d cnt0=%0d w1=%b want 0 00 0 0 1", avm_write, grant, cnt1, cnt0, r1_waitrequest); end
    step();
    avm_waitrequest = 0;
    reset_n = 1;
    #1;
    checks++;
    if (grant !== 2'b00)
      begin errors++; $display("FAIL midrst_release: grant=%b want 00", grant); end
    step();
    checks++;
    if (grant !== 2'b10 || cnt1 !== 16'd0)
      begin errors++; $display("FAIL midrst_restart: grant=%b cnt1=%0d want 10 0", grant, cnt1); end
    step();
    r1_write = 0;
    #1;
    checks++;
    if (cnt1 !== 16'd1 || grant !== 2'b00)
      begin errors++; $display("FAIL midrst_count: cnt1=%0d grant=%b want 1 00", cnt1, grant); end
  endtask

  task automatic test_wrap();
    do_reset();
    r0_read = 1; r0_lock = 1;
    step();
    repeat (65535) step();
    checks++;
    if (cnt0 !== 16'hFFFF || grant !== 2'b01)
      begin errors++; $display("FAIL wrap_max: cnt0=%h grant=%b want ffff 01", cnt0, grant); end
    step();
    checks++;
    if (cnt0 !== 16'h0000)
      begin errors++; $display("FAIL wrap_zero: cnt0=%h want 0000", cnt0); end
    r0_read = 0; r0_lock = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_wait();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
